id_fetch_arbiter: RTL and testbench

Two-requester arbiter in front of the decode stage. It shares the single decoder/issue pipeline register between the frontend fetch stream (source 0) and an injection stream (source 1, e.g. debug program buffer or microcode sequencer). Arbitration is round-robin with a sequence lock for multi-beat packets. It holds one registered output entry and uses the same valid/ack handshake the issue stage already applies to decode.

---
 rtl/id_fetch_arbiter.sv | 142 ++++++++++++++
 tb/tb_id_fetch_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_fetch_arbiter.sv
// Round-robin arbiter sharing the decode register between fetch and injection.
// Multi-beat packets lock the winning source until their last beat.
module id_fetch_arbiter #(
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic              req0_last_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  input  logic              req1_last_i,
  output logic              req1_ready_o,
  output logic              dec_valid_o,
  output logic [DATA_W-1:0] dec_data_o,
  output logic              dec_src_o,
  input  logic              dec_ack_i,
  output logic              lock_err_o
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_LOCK);

  localparam logic [1:0] LK_NONE = 2'd0;
  localparam logic [1:0] LK_S0   = 2'd1;
  localparam logic [1:0] LK_S1   = 2'd2;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic [1:0]        lock_q, lock_d;
  logic              rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              space;
  logic [1:0]        gnt;
  logic              gsrc;
  logic              glast;
  logic [DATA_W-1:0] gdata;
  logic              other_v;

  assign space = !valid_q || dec_ack_i;

  always_comb begin
    gnt = 2'b00;
    if (rst_ni && space && !flush_i) begin
      unique case (lock_q)
        LK_S0: gnt[0] = req0_valid_i;
        LK_S1: gnt[1] = req1_valid_i;
        default: begin
          if (req0_valid_i && req1_valid_i) begin
            gnt[0] = rr_q;
            gnt[1] = !rr_q;
          end else begin
            gnt = {req1_valid_i, req0_valid_i};
          end
        end
      endcase
    end
  end

  assign gsrc  = gnt[1];
  assign glast = gsrc ? req1_last_i : req0_last_i;
  assign gdata = gsrc ? req1_data_i : req0_data_i;

  // Valid of the source shut out by the current lock.
  always_comb begin
    other_v = 1'b0;
    unique case (lock_q)
      LK_S0:   other_v = req1_valid_i;
      LK_S1:   other_v = req0_valid_i;
      default: other_v = 1'b0;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (cnt_q == CMAX && other_v) begin
      err_d = 1'b1;
    end
    if (flush_i) begin
      valid_d = 1'b0;
      lock_d  = LK_NONE;
      cnt_d   = '0;
    end else if (|gnt) begin
      valid_d = 1'b1;
      data_d  = gdata;
      src_d   = gsrc;
      rr_d    = gsrc;
      if (glast) begin
        lock_d = LK_NONE;
        cnt_d  = '0;
      end else begin
        lock_d = gsrc ? LK_S1 : LK_S0;
        if (cnt_q != CMAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else if (dec_ack_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
      lock_q  <= LK_NONE;
      rr_q    <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign dec_valid_o  = valid_q;
  assign dec_data_o   = data_q;
  assign dec_src_o    = src_q;
  assign lock_err_o   = err_q;

endmodule

// File: tb/tb_id_fetch_arbiter.sv
// Directed bench for id_fetch_arbiter: reset, round-robin, lock,
// backpressure, flush and lock error scenarios.
module tb_id_fetch_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          v0, v1, l0, l1, r0, r1;
  logic [DW-1:0] d0, d1;
  logic          dv, dsrc, ack, err;
  logic [DW-1:0] ddata;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  id_fetch_arbiter #(.DATA_W(DW), .MAX_LOCK(4)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .flush_i(flush),
    .req0_valid_i(v0),
    .req0_data_i(d0),
    .req0_last_i(l0),
    .req0_ready_o(r0),
    .req1_valid_i(v1),
    .req1_data_i(d1),
    .req1_last_i(l1),
    .req1_ready_o(r1),
    .dec_valid_o(dv),
    .dec_data_o(ddata),
    .dec_src_o(dsrc),
    .dec_ack_i(ack),
    .lock_err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    l0 = 1'b1; l1 = 1'b1;
    d0 = '0; d1 = '0;
    ack = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    l0 = 1'b1; l1 = 1'b1;
    d0 = 16'hA001; d1 = 16'hB001;
    ack = 1'b1;
    tick();
    tick();
    total++;
    if ({r0, r1} !== 2'b00)
      $display("FAIL reset_ready got %b want 00", {r0, r1});
    else pass_cnt++;
    total++;
    if ({dv, dsrc, ddata, err} !== {1'b0, 1'b0, 16'h0, 1'b0})
      $display("FAIL reset_out got v=%b s=%b d=%h e=%b want 0 0 0000 0",
               dv, dsrc, ddata, err);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total++;
    if ({r0, r1} !== 2'b10)
      $display("FAIL reset_first_ready got %b want 10", {r0, r1});
    else pass_cnt++;
    tick();
    total++;
    if ({dv, dsrc, ddata} !== {1'b1, 1'b0, 16'hA001})
      $display("FAIL reset_first_out got v=%b s=%b d=%h want 1 0 a001",
               dv, dsrc, ddata);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic exp;
    do_reset();
    v0 = 1'b1; v1 = 1'b1;
    exp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d0 = 16'h0100 + 16'(i);
      d1 = 16'h1100 + 16'(i);
      #1;
      total++;
      if ({r1, r0} !== (exp ? 2'b10 : 2'b01))
        $display("FAIL rr_ready[%0d] got r1r0=%b want src %0d", i, {r1, r0}, exp);
      else pass_cnt++;
      tick();
      total++;
      if ({dv, dsrc, ddata} !== {1'b1, exp, exp ? 16'h1100 + 16'(i) : 16'h0100 + 16'(i)})
        $display("FAIL rr_out[%0d] got v=%b s=%b d=%h want src %0d",
                 i, dv, dsrc, ddata, exp);
      else pass_cnt++;
      exp = ~exp;
    end
  endtask

  task automatic test_lock();
    logic [3:0] lasts;
    do_reset();
    v0 = 1'b1; d0 = 16'h0200;
    tick();
    v1 = 1'b1;
    lasts = 4'b0100;
    for (int b = 0; b < 3; b++) begin
      l1 = lasts[b];
      d1 = 16'h2200 + 16'(b);
      #1;
      total++;
      if ({r1, r0} !== 2'b10)
        $display("FAIL lock_ready[%0d] got r1r0=%b want 10", b, {r1, r0});
      else pass_cnt++;
      tick();
      total++;
      if ({dv, dsrc, ddata} !== {1'b1, 1'b1, 16'h2200 + 16'(b)})
        $display("FAIL lock_out[%0d] got v=%b s=%b d=%h want 1 1 %h",
                 b, dv, dsrc, ddata, 16'h2200 + 16'(b));
      else pass_cnt++;
    end
    v1 = 1'b0;
    d0 = 16'h0201;
    tick();
    total++;
    if ({dv, dsrc, ddata} !== {1'b1, 1'b0, 16'h0201})
      $display("FAIL lock_after got v=%b s=%b d=%h want 1 0 0201", dv, dsrc, ddata);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    v0 = 1'b1; d0 = 16'h0300;
    tick();
    ack = 1'b0;
    d0 = 16'h0301;
    v1 = 1'b1; d1 = 16'h1301;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({r1, r0} !== 2'b00)
        $display("FAIL bp_ready[%0d] got r1r0=%b want 00", i, {r1, r0});
      else pass_cnt++;
      tick();
      total++;
      if ({dv, ddata} !== {1'b1, 16'h0300})
        $display("FAIL bp_hold[%0d] got v=%b d=%h want 1 0300", i, dv, ddata);
      else pass_cnt++;
    end
    ack = 1'b1;
    #1;
    total++;
    if ({r1, r0} !== 2'b10)
      $display("FAIL bp_release_ready got r1r0=%b want 10", {r1, r0});
    else pass_cnt++;
    tick();
    total++;
    if ({dv, dsrc, ddata} !== {1'b1, 1'b1, 16'h1301})
      $display("FAIL bp_release got v=%b s=%b d=%h want 1 1 1301", dv, dsrc, ddata);
    else pass_cnt++;
    tick();
    total++;
    if ({dv, dsrc, ddata} !== {1'b1, 1'b0, 16'h0301})
      $display("FAIL bp_next got v=%b s=%b d=%h want 1 0 0301", dv, dsrc, ddata);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    v0 = 1'b1; l0 = 1'b0; d0 = 16'h0400;
    tick();
    d0 = 16'h0401;
    tick();
    flush = 1'b1;
    v1 = 1'b1; d1 = 16'h1400;
    #1;
    total++;
    if ({r1, r0} !== 2'b00)
      $display("FAIL flush_ready got r1r0=%b want 00", {r1, r0});
    else pass_cnt++;
    tick();
    total++;
    if (dv !== 1'b0)
      $display("FAIL flush_valid got %b want 0", dv);
    else pass_cnt++;
    flush = 1'b0;
    v0 = 1'b0;
    #1;
    total++;
    if ({r1, r0} !== 2'b10)
      $display("FAIL flush_unlock_ready got r1r0=%b want 10", {r1, r0});
    else pass_cnt++;
    tick();
    total++;
    if ({dv, dsrc, ddata} !== {1'b1, 1'b1, 16'h1400})
      $display("FAIL flush_unlock got v=%b s=%b d=%h want 1 1 1400", dv, dsrc, ddata);
    else pass_cnt++;
    v1 = 1'b0;
  endtask

  task automatic test_lock_err();
    do_reset();
    v0 = 1'b1; v1 = 1'b1;
    d1 = 16'h1500;
    for (int b = 0; b < 6; b++) begin
      l0 = (b == 5);
      d0 = 16'h0500 + 16'(b);
      #1;
      total++;
      if ({r1, r0} !== 2'b01)
        $display("FAIL lerr_ready[%0d] got r1r0=%b want 01", b, {r1, r0});
      else pass_cnt++;
      tick();
      if (b == 2) begin
        total++;
        if (err !== 1'b0)
          $display("FAIL lerr_early got %b want 0", err);
        else pass_cnt++;
      end
    end
    total++;
    if (err !== 1'b1)
      $display("FAIL lerr_after_pkt got %b want 1", err);
    else pass_cnt++;
    l0 = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    total++;
    if (err !== 1'b1)
      $display("FAIL lerr_after_flush got %b want 1", err);
    else pass_cnt++;
    do_reset();
    total++;
    if (err !== 1'b0)
      $display("FAIL lerr_reset got %b want 0", err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_flush();
    test_lock_err();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
